// File: rtl/cpu_nic.sv
// Network interface between the processor data-memory port and a mesh router local port.
// Exposes four memory-mapped registers; one-packet buffers in each direction.
module cpu_nic #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [0:DATA_WIDTH-1] d_in,
    output logic [0:DATA_WIDTH-1] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity
);

    typedef enum logic [1:0] {
        REG_IN_BUF     = 2'b00,
        REG_IN_STATUS  = 2'b01,
        REG_OUT_BUF    = 2'b10,
        REG_OUT_STATUS = 2'b11
    } reg_sel_t;

    logic [0:DATA_WIDTH-1] in_buf;
    logic [0:DATA_WIDTH-1] out_buf;
    logic                  in_full;
    logic                  out_full;

    reg_sel_t              sel;
    logic                  rd_en;
    logic                  wr_en;
    logic                  capture;
    logic [0:DATA_WIDTH-1] rd_data;

    assign sel     = reg_sel_t'(addr[1:0]);
    assign rd_en   = nicEn & ~nicWrEn;
    assign wr_en   = nicEn & nicWrEn & (sel == REG_OUT_BUF);

    assign net_ri  = ~in_full;
    assign net_do  = out_buf;
    // Inject only when the packet's VC bit matches the router's current phase.
    assign net_so  = out_full & net_ro & (out_buf[0] == net_polarity);
    assign capture = net_si & net_ri;

    always_comb begin
        rd_data = '0;
        unique case (sel)
            REG_IN_BUF:     rd_data = in_buf;
            REG_IN_STATUS:  rd_data[0] = in_full;
            REG_OUT_BUF:    rd_data = out_buf;
            REG_OUT_STATUS: rd_data[0] = out_full;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_buf   <= '0;
            out_buf  <= '0;
            in_full  <= 1'b0;
            out_full <= 1'b0;
            d_out    <= '0;
        end else begin
            if (rd_en)
                d_out <= rd_data;

            // capture needs in_full==0 and draining needs in_full==1, so they never collide
            if (capture) begin
                in_buf  <= net_di;
                in_full <= 1'b1;
            end else if (rd_en && sel == REG_IN_BUF && in_full) begin
                in_full <= 1'b0;
            end

            if (wr_en && !out_full) begin
                out_buf  <= d_in;
                out_full <= 1'b1;
            end else if (net_so) begin
                out_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_nic.sv
// Scoreboard bench for cpu_nic: a queue-based reference model predicts router-side
// outputs and read data; a separate monitor compares them against the DUT.
module tb_cpu_nic;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic [0:63] d_in;
    logic [0:63] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [0:63] net_di;
    logic        net_so;
    logic        net_ro;
    logic [0:63] net_do;
    logic        net_polarity;

    cpu_nic #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
        .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(net_polarity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        time         due;
        logic        ri;
        logic        so;
        logic [0:63] pkt;
    } comb_exp_t;

    typedef struct {
        time         due;
        logic [0:63] val;
    } dout_exp_t;

    comb_exp_t comb_q[$];
    dout_exp_t dout_q[$];

    int errors = 0;
    int checks = 0;

    // Reference model: each direction is a queue holding at most one packet.
    logic [0:63] in_q[$];
    logic [0:63] out_q[$];
    logic [0:63] m_in_buf;
    logic [0:63] m_out_buf;
    logic [0:63] m_dout;

    task automatic model_reset();
        in_q.delete();
        out_q.delete();
        m_in_buf  = '0;
        m_out_buf = '0;
        m_dout    = '0;
    endtask

    task automatic step(input logic rst, input logic en, input logic we, input logic [1:0] a,
                        input logic [0:63] din, input logic si, input logic [0:63] di,
                        input logic ro, input logic pol);
        comb_exp_t   ce;
        dout_exp_t   de;
        logic [0:63] status;
        logic        ri_now;
        logic        so_now;
        logic        is_read;

        reset = rst; nicEn = en; nicWrEn = we; addr = a; d_in = din;
        net_si = si; net_di = di; net_ro = ro; net_polarity = pol;

        ri_now = (in_q.size() == 0);
        so_now = (out_q.size() != 0) && ro && (out_q[0][0] == pol);
        ce.due = $time + 4; ce.ri = ri_now; ce.so = so_now; ce.pkt = m_out_buf;
        comb_q.push_back(ce);

        if (!rst) begin
            model_reset();
        end else begin
            is_read = en && !we;
            if (is_read) begin
                status = '0;
                case (a)
                    2'b00: begin
                        m_dout = m_in_buf;
                        if (in_q.size() != 0) void'(in_q.pop_front());
                    end
                    2'b01: begin status[0] = (in_q.size() != 0); m_dout = status; end
                    2'b10: m_dout = m_out_buf;
                    default: begin status[0] = (out_q.size() != 0); m_dout = status; end
                endcase
            end
            if (si && ri_now) begin
                in_q.push_back(di);
                m_in_buf = di;
            end
            if (so_now)
                void'(out_q.pop_front());
            else if (en && we && a == 2'b10 && out_q.size() == 0) begin
                out_q.push_back(din);
                m_out_buf = din;
            end
        end
        de.due = $time + 14; de.val = m_dout;
        dout_q.push_back(de);

        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 2'b00, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [1:0] a);
        step(1'b1, 1'b1, 1'b0, a, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Monitor: compares DUT outputs whenever a predicted observation falls due.
    initial begin
        comb_exp_t ce;
        dout_exp_t de;
        forever begin
            @(negedge clk);
            while (comb_q.size() != 0 && comb_q[0].due <= $time) begin
                ce = comb_q.pop_front();
                checks += 3;
                if (net_ri !== ce.ri) begin
                    errors++;
                    $display("FAIL net_ri t=%0t actual=%b required=%b", $time, net_ri, ce.ri);
                end
                if (net_so !== ce.so) begin
                    errors++;
                    $display("FAIL net_so t=%0t actual=%b required=%b", $time, net_so, ce.so);
                end
                if (net_do !== ce.pkt) begin
                    errors++;
                    $display("FAIL net_do t=%0t actual=%h required=%h", $time, net_do, ce.pkt);
                end
            end
            while (dout_q.size() != 0 && dout_q[0].due <= $time) begin
                de = dout_q.pop_front();
                checks++;
                if (d_out !== de.val) begin
                    errors++;
                    $display("FAIL d_out t=%0t actual=%h required=%h", $time, d_out, de.val);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    localparam logic [0:63] PKT_A = 64'h8000_0000_0000_00AA;
    localparam logic [0:63] PKT_B = 64'h0000_0000_0000_AAAA;

    initial begin
        reset = 1'b0; nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'b00; d_in = '0;
        net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;

        // reset state and status reads
        step(1'b0, 1'b0, 1'b0, 2'b00, '0, 1'b0, '0, 1'b0, 1'b0);
        idle();
        rd(2'b01);
        rd(2'b11);
        idle();

        // polarity-gated send
        step(1'b1, 1'b1, 1'b1, 2'b10, PKT_A, 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 2'b00, '0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 2'b00, '0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 2'b11, '0, 1'b0, '0, 1'b1, 1'b1);
        idle();

        // write dropped while full, accepted after drain
        step(1'b1, 1'b1, 1'b1, 2'b10, PKT_B, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 2'b10, 64'h1234, 1'b0, '0, 1'b0, 1'b0);
        rd(2'b10);
        step(1'b1, 1'b0, 1'b0, 2'b00, '0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 2'b10, 64'h1234, 1'b0, '0, 1'b0, 1'b0);
        rd(2'b10);
        step(1'b1, 1'b0, 1'b0, 2'b00, '0, 1'b0, '0, 1'b1, 1'b0);

        // receive, hold-off, read-out
        step(1'b1, 1'b0, 1'b0, 2'b00, '0, 1'b1, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 2'b00, '0, 1'b1, 64'h55, 1'b0, 1'b0);
        rd(2'b01);
        rd(2'b00);
        idle();

        // read of empty in_buf coinciding with capture
        step(1'b1, 1'b1, 1'b0, 2'b00, '0, 1'b1, 64'h77, 1'b0, 1'b0);
        rd(2'b00);
        idle();

        // reset overrides full buffers and a pending capture/send
        step(1'b1, 1'b1, 1'b1, 2'b10, PKT_A, 1'b1, 64'h99, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 2'b00, '0, 1'b1, 64'hABCD, 1'b1, 1'b1);
        idle();
        rd(2'b00);
        rd(2'b01);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [0:63] din;
            logic [0:63] di;
            din = {$urandom, $urandom};
            di  = {$urandom, $urandom};
            step(($urandom_range(0, 99) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)), din, $urandom_range(0, 2) == 0, di,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        end

        idle();
        idle();
        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_nic.md
Name: cpu_nic

Overview:
- Network interface controller between the four-stage processor's data-memory port and the local port of a mesh router.
- Processor sees it as four 64-bit memory-mapped registers: input buffer, input status, output buffer, output status.
- Router side uses one-packet-deep send/ready channels in each direction.
- Polarity gating on the output channel ensures injection only on the matching virtual-channel phase.

Parameters:
- DATA_WIDTH, 64, packet and register width (bit 0 is MSB; bit 0 of a packet is its VC bit).
- ADDR_WIDTH, 2, register select width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset; asserted while 0 at a posedge.
- addr  input  2  register select from processor: 00 in_buf, 01 in_status, 10 out_buf, 11 out_status.
- d_in  input  64  write data from processor.
- d_out  output  64  registered read data to processor.
- nicEn  input  1  access enable.
- nicWrEn  input  1  1 = write, 0 = read (qualified by nicEn).
- net_si  input  1  router presents a packet to NIC.
- net_ri  output  1  NIC can accept a packet.
- net_di  input  64  packet from router.
- net_so  output  1  NIC presents a packet to router.
- net_ro  input  1  router can accept a packet.
- net_do  output  64  packet to router.
- net_polarity  input  1  router VC phase.

Behaviour:
- State: in_buf[0:63], in_full, out_buf[0:63], out_full, d_out register.
- Reset (reset==0 at posedge): in_buf, out_buf, in_full, out_full and d_out all cleared to 0. Resulting outputs: net_ri=1, net_so=0, net_do=0. Reset overrides every simultaneous event, including pending handshakes.
- Processor read (nicEn=1, nicWrEn=0 at posedge N): d_out loads the selected value at N, visible after N (one-cycle latency, same as dmem). d_out holds until the next read.
  - 00: in_buf. If in_full=1, in_full clears at the same edge. If in_full=0, returns stale in_buf with no side effect.
  - 01: {in_full, 63'b0}, i.e. status in bit 0.
  - 10: out_buf.
  - 11: {out_full, 63'b0}.
- Processor write (nicEn=1, nicWrEn=1):
  - Only addr 10 is writable.
  - If out_full==0 at the edge: out_buf<=d_in and out_full<=1.
  - If out_full==1 at the edge (including the edge where it drains): write is dropped.
  - Writes to 00, 01, 11 are ignored. d_out is unchanged by writes.
- nicEn=0: no processor-side effect.
- Output channel (combinational):
  - net_do = out_buf.
  - net_so = out_full & net_ro & (out_buf[0] == net_polarity).
  - At a posedge with net_so=1, out_full<=0. out_buf keeps its value.
- Input channel:
  - net_ri = ~in_full (combinational).
  - At a posedge with net_si & net_ri: in_buf<=net_di and in_full<=1.
  - net_si while net_ri=0 is ignored; the router must hold.
- Simultaneous events:
  - Read of 00 with in_full=0 plus net_si capture at the same edge: the capture wins, in_full=1, and d_out gets the old in_buf.
  - Read of 00 with in_full=1: net_ri=0, so no capture can coincide.
- Status reads sample pre-edge values.
- Send and receive proceed independently in the same cycle.

Test Plan:
- Reset then release: d_out=0, net_ri=1, net_so=0. Read 01 and 11 -> d_out=0 both, one cycle after each read.
- Write 10 with d_in=64'h8000_0000_0000_00AA, net_ro=1, net_polarity=0 -> net_so stays 0. Set polarity=1 -> net_so=1 with net_do=64'h8000_0000_0000_00AA. After that edge, out_full=0 and a read of 11 returns 0.
- With out_full=1 and net_ro=0, write 10 with 64'h1234 -> dropped; out_buf keeps its old value. Then drain, write 64'h1234 -> accepted.
- net_si=1 with net_di=64'h0000_0000_DEAD_BEEF -> net_ri falls the next cycle; read 01 -> bit0=1. A second net_si with 64'h55 -> ignored. Read 00 -> d_out=64'hDEAD_BEEF, then net_ri=1.
- Read 00 with in_full=0 at the same edge as net_si, net_di=64'h77 -> d_out=old in_buf, in_full=1. The next read of 00 -> 64'h77.
- Assert reset while both buffers are full and net_si=1 -> all state is 0 after that edge and no packet is captured.
